// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller: stage index
// constants, default stall-vector width, default non-abortable request mask
// and the controller FSM state encoding.
package pipe_hazard_ctrl_pkg;

    // Stage indices into the stall vector, oldest stage at bit 0
    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    localparam int STAGES_DEFAULT = 6;

    // A data-memory transaction cannot be abandoned half way
    localparam logic [STAGES_DEFAULT-1:0] NOABORT_MASK_DEFAULT = 6'b010000;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundle between the pipeline and the hazard controller.
//   stall_req  : per-stage hold requests (bit k = stage k)
//   excp_valid : exception committed this cycle
//   excp_pc    : exception handler address
//   stall      : thermometer stall vector back to the pipeline registers
//   flush      : flush all pipeline registers this cycle
//   new_pc     : redirect PC, valid while flush is high
// master = pipeline side, slave = controller side.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int STAGES = STAGES_DEFAULT
);

    logic [STAGES-1:0] stall_req;
    logic              excp_valid;
    logic [31:0]       excp_pc;
    logic [STAGES-1:0] stall;
    logic              flush;
    logic [31:0]       new_pc;

    modport master (
        output stall_req, excp_valid, excp_pc,
        input  stall, flush, new_pc
    );

    modport slave (
        input  stall_req, excp_valid, excp_pc,
        output stall, flush, new_pc
    );

endinterface

// File: rtl/pipe_hazard_ctrl_stall_wdog.sv
// stall_wdog
// Counts consecutive stalled cycles and raises a sticky timeout flag once the
// count reaches WDOG_LIMIT. The counter saturates at WDOG_LIMIT.
//   clk, rst      : clock, synchronous active-high reset
//   stalling      : pipeline is stalled (and not flushing) this cycle
//   stall_timeout : sticky flag, cleared only by rst
module stall_wdog #(
    parameter int WDOG_W     = 11,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stalling,
    output logic stall_timeout
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_LIMIT);

    logic [WDOG_W-1:0] count_q;
    logic [WDOG_W-1:0] count_d;
    logic              timeout_q;

    // Any non-stalled cycle restarts the streak
    always_comb begin
        count_d = '0;
        if (stalling) begin
            count_d = (count_q == LIMIT) ? count_q : count_q + 1'b1;
        end
    end

    // The flag is set from the next count so it rises in step with the count
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_q | (count_d == LIMIT);
        end
    end

    assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline hazard controller: decodes per-stage stall requests into a
// thermometer stall vector, turns exceptions into a one-cycle flush with a
// redirect PC (deferred while a non-abortable stall is in flight), runs a
// stall watchdog and optional performance counters.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : stall_req/excp_valid/excp_pc in, stall/flush/new_pc out
//   stall_timeout     : sticky watchdog flag
//   perf_stall_cycles : cycles with a non-zero stall vector
//   perf_flush_cnt    : flushes issued
// Build option: define PIPE_HAZARD_PERF_EN to build the perf counters;
// otherwise both perf outputs read 0.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int                STAGES       = STAGES_DEFAULT,
    parameter logic [STAGES-1:0] NOABORT_MASK = NOABORT_MASK_DEFAULT,
    parameter int                EXCP_STAGE   = STAGE_MEM,
    parameter int                WDOG_LIMIT   = 1024,
    parameter int                WDOG_W       = 11
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus,
    output logic                stall_timeout,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_flush_cnt
);

    // Stages [EXCP_STAGE:0] stay frozen while an exception waits to flush
    localparam logic [STAGES-1:0] EXCP_MASK =
        STAGES'((64'd1 << (EXCP_STAGE + 1)) - 64'd1);

    hz_state_t         state_q;
    hz_state_t         state_d;
    logic [31:0]       pend_pc_q;
    logic [31:0]       pend_pc_d;
    logic [STAGES-1:0] decoded;
    logic [STAGES-1:0] stall_o;
    logic              flush_o;
    logic [31:0]       new_pc_o;
    logic              noabort_active;
    logic              wdog_stalling;

    // Thermometer decode: a stage stalls if it or any younger stage requests
    always_comb begin
        logic seen;
        seen    = 1'b0;
        decoded = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            seen       = seen | bus.stall_req[k];
            decoded[k] = seen;
        end
    end

    assign noabort_active = |(bus.stall_req & NOABORT_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Flush wins over every stall request; reset forces all outputs low
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        stall_o   = decoded;
        flush_o   = 1'b0;
        new_pc_o  = '0;
        unique case (state_q)
            RUN: begin
                if (bus.excp_valid) begin
                    if (!noabort_active) begin
                        flush_o  = 1'b1;
                        new_pc_o = bus.excp_pc;
                        stall_o  = '0;
                    end else begin
                        state_d   = PEND;
                        pend_pc_d = bus.excp_pc;
                    end
                end
            end
            PEND: begin
                if (!noabort_active) begin
                    flush_o  = 1'b1;
                    new_pc_o = pend_pc_q;
                    stall_o  = '0;
                    state_d  = RUN;
                end else begin
                    stall_o = decoded | EXCP_MASK;
                end
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            stall_o  = '0;
            flush_o  = 1'b0;
            new_pc_o = '0;
        end
    end

    assign bus.stall  = stall_o;
    assign bus.flush  = flush_o;
    assign bus.new_pc = new_pc_o;

    assign wdog_stalling = (|stall_o) && !flush_o;

    stall_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk           (clk),
        .rst           (rst),
        .stalling      (wdog_stalling),
        .stall_timeout (stall_timeout)
    );

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Free-running counters, wrap modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (|stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_o)  flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_cnt    = flush_cnt_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_cnt    = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the in-order CPU core. It collects per-stage stall requests and derives the thermometer stall vector that freezes a stage and every older stage, with a bubble inserted downstream. It also turns exception requests into a single-cycle flush with a redirect PC, deferring the flush while a non-abortable stall (e.g. a data-memory transaction) is in flight. It sits beside the PC/IF/ID/EX/MEM/WB pipeline registers and drives their stall and flush inputs.

## Interface
- STAGES, 6, stall-vector width; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- NOABORT_MASK, 6'b010000, request bits whose stall must complete before a flush may issue.
- EXCP_STAGE, 4, minimum stall depth held while a flush is pending (bits [EXCP_STAGE:0]).
- WDOG_LIMIT, 1024, consecutive stall cycles before the timeout flag sets.
- WDOG_W, 11, watchdog counter width; must hold WDOG_LIMIT.
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- stall_req  in  STAGES  bit k = stage k must hold this cycle.
- excp_valid  in  1  exception committed this cycle.
- excp_pc  in  32  handler address.
- stall  out  STAGES  thermometer stall vector.
- flush  out  1  flush all pipeline registers this cycle.
- new_pc  out  32  redirect PC, valid when flush = 1.
- stall_timeout  out  1  sticky watchdog flag.
- perf_stall_cycles  out  32  cycles with stall ≠ 0.
- perf_flush_cnt  out  32  flushes issued.

## Operation
- Stall decode: h = highest set index of stall_req; stall = ones over [h:0]; stall = 0 when stall_req = 0.
- FSM states: RUN and PEND.
  - RUN, excp_valid = 1, (stall_req & NOABORT_MASK) = 0: flush = 1, new_pc = excp_pc, stall = 0; stay in RUN.
  - RUN, excp_valid = 1, non-abortable request active: latch excp_pc into pend_pc and go to PEND; flush = 0.
  - PEND: stall = decoded | ones[EXCP_STAGE:0]; excp_valid ignored (first exception wins).
  - PEND, non-abortable requests clear: flush = 1, new_pc = pend_pc, stall = 0; next state RUN.
- Flush overrides every stall request in the cycle it is asserted.
- new_pc = 0 whenever flush = 0.
- Watchdog counter:
  - Increments on each cycle with stall ≠ 0 and flush = 0; saturates.
  - Clears on any cycle with stall = 0 or flush = 1.
  - stall_timeout sets when count reaches WDOG_LIMIT; it stays set until rst.
- Perf counters: see Configuration; both wrap modulo 2^32.

## Timing
- stall, flush and new_pc are combinational from inputs and registered state, with zero-cycle latency, so a load-use hazard stalls in the same cycle.
- Deferred flush asserts in the first cycle in which the non-abortable bits are low, and lasts exactly one cycle.
- Reset (rst = 1 at a rising edge) state: FSM RUN, pend_pc 0, watchdog 0, stall_timeout 0, perf counters 0.
- While rst is high, the outputs are forced: stall 0, flush 0, new_pc 0.
- Reset mid-PEND: the pending exception is discarded and no flush is issued afterwards.
- rst has priority over excp_valid and stall_req.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - perf_stall_cycles increments on each cycle with stall ≠ 0.
  - perf_flush_cnt increments on each cycle with flush = 1.
- PIPE_HAZARD_PERF_EN undefined: both ports remain but are tied to 0, and no counter flops are built.

## Structure
- The shared package holds:
  - stage index constants (PC, IF, ID, EX, MEM, WB);
  - STAGES default;
  - FSM state encoding (RUN = 1'b0, PEND = 1'b1);
  - default NOABORT_MASK.
- One sub-module, stall_wdog: saturating counter plus sticky timeout flag, parametrised by WDOG_W and WDOG_LIMIT.

## Test plan
- stall_req = 6'b000100 -> stall = 6'b000111 in the same cycle; flush = 0.
- stall_req = 6'b001100 -> stall = 6'b001111.
- stall_req = 0, excp_valid = 1, excp_pc = 0xBFC00380 -> same cycle: flush = 1, new_pc = 0xBFC00380, stall = 0; next cycle flush = 0.
- Deferred flush:
  - Stimulus: stall_req[4] = 1 for cycles 0–2, excp_valid with 0x80000180 at cycle 0, second excp_valid with 0x80000200 at cycle 1.
  - Cycles 0–2: stall = 6'b011111, flush = 0.
  - Cycle 3: flush = 1, new_pc = 0x80000180.
- WDOG_LIMIT = 16, stall_req[3] held for 20 cycles -> stall_timeout rises after 16 stall cycles and stays set after the request drops.
- Reset and perf counters:
  - rst pulsed while in PEND -> no flush ever follows.
  - With PIPE_HAZARD_PERF_EN, 5 stall cycles + 2 flushes -> perf_stall_cycles = 5, perf_flush_cnt = 2.
  - Without the macro, both counters read 0.
